// File: rtl/bird_motion.sv
`default_nettype none
// ============================================================================
// Module      : bird_motion
// Description : Vertical-motion engine for the bird sprite. Owns the bird row,
//               its vertical velocity and the IDLE/PLAY/DEAD game state, and
//               advances the physics once per frame_tick (gravity, flap
//               impulse, boundary clamp). The downstream crash detector
//               returns game_over, which freezes the bird.
// Ports       : clk        - system clock
//               clr        - asynchronous active-high reset
//               frame_tick - one-cycle pulse per video frame
//               flap       - flap button level, synchronous to clk
//               start      - one-cycle start/restart request
//               game_over  - crash flag (level) from the crash detector
//               bird_y     - bird centre row, unsigned
//               bird_vel   - velocity, two's complement, positive = down
//               playing    - high while in PLAY
// Revision    : 1.0 - initial release
// ============================================================================
module bird_motion #(
    parameter int START_Y  = 240,
    parameter int GRAVITY  = 1,
    parameter int FLAP_VEL = 8,
    parameter int MAX_FALL = 8,
    parameter int Y_MIN    = 6,
    parameter int Y_MAX    = 474
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       frame_tick,
    input  logic       flap,
    input  logic       start,
    input  logic       game_over,
    output logic [9:0] bird_y,
    output logic [5:0] bird_vel,
    output logic       playing
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_play = 2'd1;
    localparam logic [1:0] c_st_dead = 2'd2;

    localparam logic        [9:0]  c_start_y  = 10'(START_Y);
    localparam logic signed [5:0]  c_flap_vel = 6'(-FLAP_VEL);
    localparam logic signed [6:0]  c_gravity  = 7'(GRAVITY);
    localparam logic signed [6:0]  c_max_fall = 7'(MAX_FALL);
    localparam logic signed [10:0] c_y_min    = 11'(Y_MIN);
    localparam logic signed [10:0] c_y_max    = 11'(Y_MAX);

    logic [1:0]        r_state;
    logic [9:0]        r_bird_y;
    logic signed [5:0] r_bird_vel;
    logic              r_flap_prev;
    logic              r_flap_pending;

    logic [1:0]         w_state_next;
    logic [9:0]         w_y_next;
    logic signed [5:0]  w_vel_next;
    logic               w_pending_next;

    logic               w_flap_rise;
    logic signed [6:0]  w_vel_inc;
    logic signed [5:0]  w_vel_phys;
    logic signed [10:0] w_y_sum;
    logic [9:0]         w_y_phys;

    assign w_flap_rise = flap & ~r_flap_prev;

    // Physics for the current frame. Velocity is widened by one bit so the
    // gravity add cannot wrap before it is compared to the terminal speed,
    // and the row sum is done in 11-bit signed so an upward move near the
    // top boundary goes negative instead of wrapping to a large row.
    always_comb begin
        w_vel_inc = {r_bird_vel[5], r_bird_vel} + c_gravity;
        if (r_flap_pending | w_flap_rise) begin
            w_vel_phys = c_flap_vel;
        end else if (w_vel_inc > c_max_fall) begin
            w_vel_phys = c_max_fall[5:0];
        end else begin
            w_vel_phys = w_vel_inc[5:0];
        end

        w_y_sum = $signed({1'b0, r_bird_y}) + $signed({{5{w_vel_phys[5]}}, w_vel_phys});
        if (w_y_sum < c_y_min) begin
            w_y_phys = c_y_min[9:0];
        end else if (w_y_sum > c_y_max) begin
            w_y_phys = c_y_max[9:0];
        end else begin
            w_y_phys = w_y_sum[9:0];
        end
    end

    // Next-state logic. game_over is tested before frame_tick so a crash on a
    // tick freezes the bird at its pre-tick position.
    always_comb begin
        w_state_next   = r_state;
        w_y_next       = r_bird_y;
        w_vel_next     = r_bird_vel;
        w_pending_next = r_flap_pending;

        case (r_state)
            c_st_idle: begin
                w_y_next       = c_start_y;
                w_vel_next     = '0;
                w_pending_next = 1'b0;
                if (start | w_flap_rise) begin
                    w_state_next   = c_st_play;
                    // A flap that starts the game also queues its impulse.
                    w_pending_next = w_flap_rise;
                end
            end
            c_st_play: begin
                if (game_over) begin
                    w_state_next = c_st_dead;
                end else if (frame_tick) begin
                    w_y_next       = w_y_phys;
                    w_vel_next     = w_vel_phys;
                    w_pending_next = 1'b0;
                end else if (w_flap_rise) begin
                    w_pending_next = 1'b1;
                end
            end
            c_st_dead: begin
                w_pending_next = 1'b0;
                if (start) begin
                    w_state_next = c_st_idle;
                    w_y_next     = c_start_y;
                    w_vel_next   = '0;
                end
            end
            default: begin
                w_state_next   = c_st_idle;
                w_y_next       = c_start_y;
                w_vel_next     = '0;
                w_pending_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state        <= c_st_idle;
            r_bird_y       <= c_start_y;
            r_bird_vel     <= '0;
            r_flap_prev    <= 1'b0;
            r_flap_pending <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_bird_y       <= w_y_next;
            r_bird_vel     <= w_vel_next;
            r_flap_prev    <= flap;
            r_flap_pending <= w_pending_next;
        end
    end

    assign bird_y   = r_bird_y;
    assign bird_vel = r_bird_vel;
    assign playing  = (r_state == c_st_play);

endmodule
`default_nettype wire

// File: tb/tb_bird_motion.sv
`default_nettype none
// ============================================================================
// Module      : tb_bird_motion
// Description : Self-checking bench for bird_motion. Expected outputs are
//               queued as stimulus is driven and compared one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bird_motion;

    logic       clk = 1'b0;
    logic       clr;
    logic       frame_tick;
    logic       flap;
    logic       start;
    logic       game_over;
    logic [9:0] bird_y;
    logic [5:0] bird_vel;
    logic       playing;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [9:0] y;
        logic [5:0] v;
        logic       pl;
    } exp_t;

    typedef struct {
        logic tk;
        logic fl;
        logic st;
        logic go;
        int   y;
        int   v;
        logic pl;
    } vec_t;

    exp_t sb[$];
    vec_t ff_tbl[10];

    bird_motion dut (
        .clk        (clk),
        .clr        (clr),
        .frame_tick (frame_tick),
        .flap       (flap),
        .start      (start),
        .game_over  (game_over),
        .bird_y     (bird_y),
        .bird_vel   (bird_vel),
        .playing    (playing)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input exp_t e);
        total++;
        if (bird_y !== e.y || bird_vel !== e.v || playing !== e.pl) begin
            bad++;
            $display("FAIL %s: got y=%0d vel=%0d play=%0b, want y=%0d vel=%0d play=%0b",
                     nm, bird_y, $signed(bird_vel), playing, e.y, $signed(e.v), e.pl);
        end
    endtask

    task automatic apply(input logic tk, input logic fl, input logic st, input logic go,
                         input int ey, input int ev, input logic ep, input string nm);
        exp_t e;
        frame_tick = tk;
        flap       = fl;
        start      = st;
        game_over  = go;
        e.y  = 10'(ey);
        e.v  = 6'(ev);
        e.pl = ep;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check(nm, sb.pop_front());
    endtask

    task automatic free_fall();
        for (int i = 0; i < 10; i++) begin
            apply(ff_tbl[i].tk, ff_tbl[i].fl, ff_tbl[i].st, ff_tbl[i].go,
                  ff_tbl[i].y, ff_tbl[i].v, ff_tbl[i].pl, $sformatf("free_fall_%0d", i));
        end
    endtask

    initial begin
        int ys [10] = '{241, 243, 246, 250, 255, 261, 268, 276, 284, 292};
        int vs [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8};
        int y;
        int v;
        exp_t e;

        for (int i = 0; i < 10; i++) begin
            ff_tbl[i] = '{tk: 1'b1, fl: 1'b0, st: 1'b0, go: 1'b0, y: ys[i], v: vs[i], pl: 1'b1};
        end

        clr = 1'b1; frame_tick = 1'b0; flap = 1'b0; start = 1'b0; game_over = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        e = '{y: 10'd240, v: 6'd0, pl: 1'b0};
        check("reset_state", e);
        clr = 1'b0;

        // Idle ignores ticks, start enters PLAY.
        apply(1, 0, 0, 0, 240, 0, 0, "idle_tick");
        apply(0, 0, 1, 0, 240, 0, 1, "start");
        free_fall();
        apply(0, 0, 0, 0, 292, 8, 1, "no_tick_hold");

        // Flap between ticks, then two pulses before one tick.
        apply(0, 1, 0, 0, 292, 8, 1, "flap_pending");
        apply(0, 0, 0, 0, 292, 8, 1, "flap_release");
        apply(1, 0, 0, 0, 284, -8, 1, "flap_impulse");
        apply(1, 0, 0, 0, 277, -7, 1, "after_flap");
        apply(0, 1, 0, 0, 277, -7, 1, "dbl_flap_a");
        apply(0, 0, 0, 0, 277, -7, 1, "dbl_flap_b");
        apply(0, 1, 0, 0, 277, -7, 1, "dbl_flap_c");
        apply(0, 0, 0, 0, 277, -7, 1, "dbl_flap_d");
        apply(1, 0, 0, 0, 269, -8, 1, "dbl_flap_tick");
        apply(1, 0, 0, 0, 262, -7, 1, "dbl_flap_once");

        // Rise coincident with tick applies on that tick; held level does not re-flap.
        apply(1, 1, 0, 0, 254, -8, 1, "flap_with_tick");
        apply(1, 1, 0, 0, 247, -7, 1, "flap_held");
        apply(0, 0, 0, 0, 247, -7, 1, "flap_drop");

        // Climb into the top boundary.
        y = 247;
        for (int k = 0; k < 32; k++) begin
            y = y - 8;
            if (y < 6) y = 6;
            apply(1, 1, 0, 0, y, -8, 1, "climb_tick");
            apply(0, 0, 0, 0, y, -8, 1, "climb_gap");
        end
        apply(0, 0, 0, 0, 6, -8, 1, "top_clamp");

        // Fall into the bottom boundary.
        v = -8;
        for (int k = 0; k < 80; k++) begin
            v = v + 1;
            if (v > 8) v = 8;
            y = y + v;
            if (y > 474) y = 474;
            if (y < 6) y = 6;
            apply(1, 0, 0, 0, y, v, 1, "fall_tick");
        end
        apply(0, 0, 0, 0, 474, 8, 1, "bottom_clamp");

        // Crash on a tick freezes; DEAD ignores ticks and flaps.
        apply(1, 0, 0, 1, 474, 8, 0, "crash_on_tick");
        apply(1, 1, 0, 1, 474, 8, 0, "dead_tick_flap");
        apply(1, 0, 0, 0, 474, 8, 0, "dead_tick");
        apply(0, 1, 0, 0, 474, 8, 0, "dead_flap");
        apply(0, 0, 1, 0, 240, 0, 0, "restart_idle");
        apply(1, 0, 0, 0, 240, 0, 0, "idle_after_dead");

        // Flap-start from IDLE carries its impulse into the first tick.
        apply(0, 1, 0, 0, 240, 0, 1, "flap_start");
        apply(1, 1, 0, 0, 232, -8, 1, "flap_start_tick");
        apply(0, 0, 1, 0, 232, -8, 1, "start_in_play");
        apply(0, 0, 1, 1, 232, -8, 0, "start_with_crash");
        apply(0, 0, 1, 0, 240, 0, 0, "back_to_idle");
        apply(0, 0, 1, 0, 240, 0, 1, "replay");

        // Reach y=300 then reset asynchronously mid-cycle.
        free_fall();
        apply(1, 0, 0, 0, 300, 8, 1, "reach_300");
        @(negedge clk);
        clr = 1'b1;
        #1;
        e = '{y: 10'd240, v: 6'd0, pl: 1'b0};
        check("async_clr", e);
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 0, 0, 240, 0, 0, "clr_hold");
        end
        clr = 1'b0;
        apply(1, 0, 0, 0, 240, 0, 0, "idle_post_clr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
